// File: rtl/axi4_demux.sv
// Single AXI4 slave port steered to slot_num_p master ports by addr[slot_base_bit_p +: sel_width_lp].
// Build option AXI4_DEMUX_DECERR_EN: out-of-range slots get DECERR instead of clamping to the last slot.

module axi4_demux #(
    parameter int unsigned slot_num_p      = 3,
    parameter int unsigned id_width_p      = 4,
    parameter int unsigned addr_width_p    = 32,
    parameter int unsigned data_width_p    = 64,
    parameter int unsigned slot_base_bit_p = 12,
    localparam int unsigned sel_width_lp   = (slot_num_p > 1) ? $clog2(slot_num_p) : 1,
    localparam int unsigned axi4_mosi_bus_width_lp =
        2 * (id_width_p + addr_width_p + 29) + data_width_p + data_width_p / 8 + 6,
    localparam int unsigned axi4_miso_bus_width_lp = 2 * id_width_p + data_width_p + 10
) (
    input  logic                                              clk_i,
    input  logic                                              reset_i,
    input  logic [axi4_mosi_bus_width_lp-1:0]                 s_axi4_ser_i,
    output logic [axi4_miso_bus_width_lp-1:0]                 s_axi4_ser_o,
    output logic [slot_num_p-1:0][axi4_mosi_bus_width_lp-1:0] m_axi4_par_o,
    input  logic [slot_num_p-1:0][axi4_miso_bus_width_lp-1:0] m_axi4_par_i
);

    typedef struct packed {
        logic [id_width_p-1:0]     awid;
        logic [addr_width_p-1:0]   awaddr;
        logic [7:0]                awlen;
        logic [2:0]                awsize;
        logic [1:0]                awburst;
        logic                      awlock;
        logic [3:0]                awcache;
        logic [2:0]                awprot;
        logic [3:0]                awqos;
        logic [3:0]                awregion;
        logic                      awvalid;
        logic [data_width_p-1:0]   wdata;
        logic [data_width_p/8-1:0] wstrb;
        logic                      wlast;
        logic                      wvalid;
        logic                      bready;
        logic [id_width_p-1:0]     arid;
        logic [addr_width_p-1:0]   araddr;
        logic [7:0]                arlen;
        logic [2:0]                arsize;
        logic [1:0]                arburst;
        logic                      arlock;
        logic [3:0]                arcache;
        logic [2:0]                arprot;
        logic [3:0]                arqos;
        logic [3:0]                arregion;
        logic                      arvalid;
        logic                      rready;
    } mosi_s;

    typedef struct packed {
        logic                    awready;
        logic                    wready;
        logic [id_width_p-1:0]   bid;
        logic [1:0]              bresp;
        logic                    bvalid;
        logic                    arready;
        logic [id_width_p-1:0]   rid;
        logic [data_width_p-1:0] rdata;
        logic [1:0]              rresp;
        logic                    rlast;
        logic                    rvalid;
    } miso_s;

    typedef enum logic [1:0] {WIdle, WData, WResp} wstate_e;
    typedef enum logic {RIdle, RData} rstate_e;

    localparam logic [sel_width_lp:0]   slot_num_lc  = (sel_width_lp + 1)'(slot_num_p);
    localparam logic [sel_width_lp-1:0] last_slot_lc = sel_width_lp'(slot_num_p - 1);

    mosi_s                  s_mosi;
    miso_s                  s_miso;
    mosi_s [slot_num_p-1:0] m_mosi;
    miso_s [slot_num_p-1:0] m_miso;

    assign s_mosi       = s_axi4_ser_i;
    assign s_axi4_ser_o = s_miso;
    assign m_axi4_par_o = m_mosi;
    assign m_miso       = m_axi4_par_i;

    wstate_e                 wstate_q, wstate_d;
    rstate_e                 rstate_q, rstate_d;
    logic [sel_width_lp-1:0] wsel_q, wsel_d;
    logic [sel_width_lp-1:0] rsel_q, rsel_d;
    logic [sel_width_lp-1:0] aw_idx, ar_idx;
    logic [sel_width_lp-1:0] w_slot, r_slot;

`ifdef AXI4_DEMUX_DECERR_EN
    logic                  aw_err, ar_err;
    logic                  werr_q, werr_d;
    logic                  rerr_q, rerr_d;
    logic [id_width_p-1:0] bid_q, bid_d;
    logic [id_width_p-1:0] rid_q, rid_d;
    logic [7:0]            rlen_q, rlen_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
`endif

    always_comb begin
        aw_idx = s_mosi.awaddr[slot_base_bit_p +: sel_width_lp];
        ar_idx = s_mosi.araddr[slot_base_bit_p +: sel_width_lp];
`ifdef AXI4_DEMUX_DECERR_EN
        aw_err = ({1'b0, aw_idx} >= slot_num_lc);
        ar_err = ({1'b0, ar_idx} >= slot_num_lc);
        // Latched selects of an error transaction never index the slot arrays.
        w_slot = werr_q ? '0 : wsel_q;
        r_slot = rerr_q ? '0 : rsel_q;
`else
        if ({1'b0, aw_idx} >= slot_num_lc) aw_idx = last_slot_lc;
        if ({1'b0, ar_idx} >= slot_num_lc) ar_idx = last_slot_lc;
        w_slot = wsel_q;
        r_slot = rsel_q;
`endif
    end

    always_comb begin
        for (int unsigned i = 0; i < slot_num_p; i++) begin
            m_mosi[i]         = s_mosi;
            m_mosi[i].awvalid = 1'b0;
            m_mosi[i].wvalid  = 1'b0;
            m_mosi[i].bready  = 1'b0;
            m_mosi[i].arvalid = 1'b0;
            m_mosi[i].rready  = 1'b0;
        end
        s_miso       = '0;
        s_miso.bid   = m_miso[w_slot].bid;
        s_miso.bresp = m_miso[w_slot].bresp;
        s_miso.rid   = m_miso[r_slot].rid;
        s_miso.rdata = m_miso[r_slot].rdata;
        s_miso.rresp = m_miso[r_slot].rresp;
        s_miso.rlast = m_miso[r_slot].rlast;

        wstate_d = wstate_q;
        rstate_d = rstate_q;
        wsel_d   = wsel_q;
        rsel_d   = rsel_q;
`ifdef AXI4_DEMUX_DECERR_EN
        werr_d     = werr_q;
        rerr_d     = rerr_q;
        bid_d      = bid_q;
        rid_d      = rid_q;
        rlen_d     = rlen_q;
        beat_cnt_d = beat_cnt_q;
`endif

        unique case (wstate_q)
            WIdle: begin
`ifdef AXI4_DEMUX_DECERR_EN
                if (aw_err) s_miso.awready = 1'b1;
                else
`endif
                begin
                    m_mosi[aw_idx].awvalid = s_mosi.awvalid;
                    s_miso.awready         = m_miso[aw_idx].awready;
                end
                if (s_mosi.awvalid && s_miso.awready) begin
                    wsel_d   = aw_idx;
`ifdef AXI4_DEMUX_DECERR_EN
                    werr_d   = aw_err;
                    bid_d    = s_mosi.awid;
`endif
                    wstate_d = WData;
                end
            end
            WData: begin
`ifdef AXI4_DEMUX_DECERR_EN
                if (werr_q) s_miso.wready = 1'b1;
                else
`endif
                begin
                    m_mosi[w_slot].wvalid = s_mosi.wvalid;
                    s_miso.wready         = m_miso[w_slot].wready;
                end
                if (s_mosi.wvalid && s_miso.wready && s_mosi.wlast) wstate_d = WResp;
            end
            WResp: begin
`ifdef AXI4_DEMUX_DECERR_EN
                if (werr_q) begin
                    s_miso.bvalid = 1'b1;
                    s_miso.bresp  = 2'b11;
                    s_miso.bid    = bid_q;
                end else
`endif
                begin
                    m_mosi[w_slot].bready = s_mosi.bready;
                    s_miso.bvalid         = m_miso[w_slot].bvalid;
                end
                if (s_miso.bvalid && s_mosi.bready) wstate_d = WIdle;
            end
            default: wstate_d = WIdle;
        endcase

        unique case (rstate_q)
            RIdle: begin
`ifdef AXI4_DEMUX_DECERR_EN
                if (ar_err) s_miso.arready = 1'b1;
                else
`endif
                begin
                    m_mosi[ar_idx].arvalid = s_mosi.arvalid;
                    s_miso.arready         = m_miso[ar_idx].arready;
                end
                if (s_mosi.arvalid && s_miso.arready) begin
                    rsel_d     = ar_idx;
`ifdef AXI4_DEMUX_DECERR_EN
                    rerr_d     = ar_err;
                    rid_d      = s_mosi.arid;
                    rlen_d     = s_mosi.arlen;
                    beat_cnt_d = '0;
`endif
                    rstate_d   = RData;
                end
            end
            RData: begin
`ifdef AXI4_DEMUX_DECERR_EN
                if (rerr_q) begin
                    s_miso.rvalid = 1'b1;
                    s_miso.rdata  = '0;
                    s_miso.rresp  = 2'b11;
                    s_miso.rid    = rid_q;
                    s_miso.rlast  = (beat_cnt_q == rlen_q);
                    if (s_mosi.rready) beat_cnt_d = beat_cnt_q + 8'd1;
                end else
`endif
                begin
                    m_mosi[r_slot].rready = s_mosi.rready;
                    s_miso.rvalid         = m_miso[r_slot].rvalid;
                end
                if (s_miso.rvalid && s_mosi.rready && s_miso.rlast) rstate_d = RIdle;
            end
            default: rstate_d = RIdle;
        endcase

        // Handshake signals are held low on both sides for the whole reset.
        if (reset_i) begin
            s_miso.awready = 1'b0;
            s_miso.wready  = 1'b0;
            s_miso.bvalid  = 1'b0;
            s_miso.arready = 1'b0;
            s_miso.rvalid  = 1'b0;
            for (int unsigned i = 0; i < slot_num_p; i++) begin
                m_mosi[i].awvalid = 1'b0;
                m_mosi[i].wvalid  = 1'b0;
                m_mosi[i].bready  = 1'b0;
                m_mosi[i].arvalid = 1'b0;
                m_mosi[i].rready  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wstate_q   <= WIdle;
            rstate_q   <= RIdle;
            wsel_q     <= '0;
            rsel_q     <= '0;
`ifdef AXI4_DEMUX_DECERR_EN
            werr_q     <= 1'b0;
            rerr_q     <= 1'b0;
            bid_q      <= '0;
            rid_q      <= '0;
            rlen_q     <= '0;
            beat_cnt_q <= '0;
`endif
        end else begin
            wstate_q   <= wstate_d;
            rstate_q   <= rstate_d;
            wsel_q     <= wsel_d;
            rsel_q     <= rsel_d;
`ifdef AXI4_DEMUX_DECERR_EN
            werr_q     <= werr_d;
            rerr_q     <= rerr_d;
            bid_q      <= bid_d;
            rid_q      <= rid_d;
            rlen_q     <= rlen_d;
            beat_cnt_q <= beat_cnt_d;
`endif
        end
    end

endmodule

// File: doc/axi4_demux.md
Name: axi4_demux

Overview:
- Single AXI4 slave port fanned out to slot_num_p AXI4 master ports. Each transaction is steered by an address field.
- The block is the counterpart of the slot-to-serial AXI4 mux. It sits on the PCIe/host side and distributes one serial AXI4 stream to per-slot endpoints.
- One write and one read are outstanding at a time. Write and read paths are independent.
- Out-of-range addresses are decoded to an internal error responder.

Parameters:
- slot_num_p, "inv": number of master slots, 2..16.
- id_width_p, "inv": AXI ID width.
- addr_width_p, "inv": AXI address width.
- data_width_p, "inv": AXI data width.
- slot_base_bit_p, "inv": LSB of the slot-select field. The field is addr[slot_base_bit_p +: sel_width_lp], where sel_width_lp = `BSG_SAFE_CLOG2(slot_num_p)`.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- s_axi4_ser_i  in  axi4_mosi_bus_width_lp  serial slave request bus, using `bsg_axi4_mosi_bus_width(1, id, addr, data)`.
- s_axi4_ser_o  out  axi4_miso_bus_width_lp  serial slave response bus.
- m_axi4_par_o  out  [slot_num_p][axi4_mosi_bus_width_lp]  per-slot master request buses.
- m_axi4_par_i  in  [slot_num_p][axi4_miso_bus_width_lp]  per-slot master response buses.

Behaviour:
- Bus casting uses `declare_bsg_axi4_bus_s` structs.
- Payload fields (addr, len, data, strb, id, ...) are broadcast to all slots.
- Only the selected slot sees asserted valid/ready. Every other slot sees awvalid=wvalid=arvalid=bready=rready=0.
- Pass-through is combinational: zero added latency. Only the FSM state is registered.
- Decode: idx = addr field.
  - idx < slot_num_p: route to slot idx.
  - idx >= slot_num_p: decode error (ERR target).
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE:
    - awvalid is forwarded to slot idx(awaddr); s.awready = m[idx].awready. For ERR, awready=1.
    - s.wready=0 and s.bvalid=0.
    - On AW handshake: latch wsel<=idx, werr, bid_r<=awid, then go to W_DATA.
  - W_DATA:
    - W channel routed to m[wsel]. For ERR: wready=1 and beats are discarded.
    - s.awready=0.
    - On W handshake with wlast=1, go to W_RESP.
  - W_RESP:
    - B channel routed from m[wsel]: bvalid, bid and bresp passed through; bready forwarded.
    - For ERR: bvalid=1, bresp=2'b11, bid=bid_r.
    - On B handshake, go to W_IDLE. The next AW is accepted in the cycle after that at the earliest.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE:
    - arvalid is forwarded to slot idx(araddr); arready comes from that slot. For ERR, arready=1.
    - s.rvalid=0.
    - On AR handshake: latch rsel, rerr, rid_r<=arid, rlen_r<=arlen; clear beat_cnt (8 bits); go to R_DATA.
  - R_DATA:
    - R channel routed from m[rsel]; arready=0.
    - For ERR: rvalid=1, rdata=0, rresp=2'b11, rid=rid_r, rlast=(beat_cnt==rlen_r). beat_cnt increments on each R handshake.
    - On R handshake with rlast=1, go to R_IDLE.
- Concurrency: a read and a write may be active at once, to the same slot or to different slots. There is no interaction between the paths.
- Reset values (while reset_i=1 and on the first cycle after):
  - Both FSMs are in IDLE; wsel, rsel, beat_cnt, bid_r, rid_r, rlen_r are 0.
  - While reset_i=1, every s-side ready and valid output is 0 and every m-side valid/ready is 0.
- Reset mid-transaction: the FSM is forced to IDLE and the transaction is abandoned with no error response. Downstream slots are reset by the same reset_i.
- Boundary conditions:
  - awlen/arlen=0: single beat; rlast is on the first beat.
  - arlen=255: the ERR path counts 256 beats and beat_cnt wraps exactly at the last beat.
  - An early wvalid in W_IDLE is not accepted.
  - Changing awaddr while awvalid is held without ready re-steers. The AXI rule requires stability, so this is not protected against.

Optional Feature:
- Macro: AXI4_DEMUX_DECERR_EN.
- Defined: out-of-range idx is served by the internal ERR responder described above, returning DECERR (2'b11).
- Not defined:
  - The ERR target is removed.
  - Out-of-range idx is clamped to slot slot_num_p-1, which receives the transaction normally.
  - No DECERR is generated and the beat_cnt logic is removed.

Test Plan:
- Setup for all scenarios: slot_num_p=3, slot_base_bit_p=12, data_width_p=512.
- Write routing: AW addr=0x1040, len=3, id=5 → slot1 awvalid only; 4 W beats reach slot1 with wlast on the 4th; slot1 B(id=5, OKAY) is returned on s. Slots 0 and 2 see no valid.
- Read routing with backpressure: AR addr=0x2000, len=1 → slot2 sees arvalid. Hold s.rready=0 for 3 cycles: slot2 rready=0 and data is held. Release → 2 beats are delivered, rlast on the 2nd, FSM in R_IDLE.
- DECERR with AXI4_DEMUX_DECERR_EN defined: AW addr=0x3000, len=1 → awready=1 immediately; 2 W beats are sunk; B resp=2'b11 with the latched id. AR addr=0x3000, len=2 → 3 beats of rdata=0, rresp=2'b11, rlast on the 3rd.
- Concurrency: write to slot0 and read from slot1 issued in the same cycle → both handshake in that cycle; responses return independently and in any order.
- Single-outstanding rule: a second AW presented while in W_DATA/W_RESP → awready=0 until 1 cycle after the first B handshake.
- Reset mid-burst: assert reset_i after 2 of 4 W beats → all outputs are 0 during reset. After release, a new AW to slot0 is accepted normally.
